rv32i_instr_encoder: RTL
========================

Name: rv32i_instr_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the core's main/ALU decode path.
- Accepts instruction fields (format class, registers, funct, immediate) on a valid/ready input.
- Packs them into 32-bit machine words and emits each word with its instruction-memory byte address on a valid/ready output.
- Used by the bench/loader path to fill instruction memory.
- Out-of-range or illegal requests are replaced by a canonical NOP and flagged.

Parameters:
- BASE_ADDR, 32'h0000_0000, first byte address emitted after reset/clear.
- DEPTH, 2, output buffer entries; fixed at 2 (skid buffer).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush: empties buffer, reloads address to BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  000 load, 001 store, 010 branch, 011 jal, 100 I-ALU, 101 R-type; 110/111 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  signed immediate, byte offset for branch/jal
- out_valid  out  1  word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded word
- out_addr  out  32  byte address of out_instr
- out_err  out  1  this word is a substituted NOP
- err_sticky  out  1  any substitution since reset/clear
- instr_count  out  16  words accepted at output since reset/clear, wraps at 16'hFFFF->0

Behaviour:
- Reset (rst==0 at posedge): buffer empty, out_valid=0, out_instr=0, out_err=0, in_ready=1, out_addr=BASE_ADDR, err_sticky=0, instr_count=0.
- Opcodes: load 0000011, store 0100011, branch 1100011, jal 1101111, I-ALU 0010011, R 0110011.
- Field placement is standard RV32I:
  - I/load: imm[11:0] in [31:20].
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7].
  - J: imm[20|10:1|11|19:12] in [31:12].
  - R: funct7 in [31:25].
  - rd, rs1, rs2 and funct3 occupy their standard fields wherever the format has them; unused fields are 0.
- Range checks, all on signed in_imm:
  - I/load/store: -2048..2047.
  - Branch: -4096..4094, bit0 must be 0.
  - Jal: -1048576..1048574, bit0 must be 0.
  - Failure, or in_fmt 110/111, produces out_instr=32'h0000_0013 with out_err=1 and sets err_sticky.
- Handshake: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
- Latency: word accepted at posedge N appears on out_valid from N+1.
- Buffer:
  - 2-entry FIFO; in_ready = (count<2), registered, no combinational path from out_ready.
  - Simultaneous push and pop at count=2 is not allowed, since in_ready=0.
  - Push and pop together at count=1 keeps count=1.
- Outputs held stable while out_valid && !out_ready.
- Address:
  - out_addr is a register, presented with the head word.
  - +4 on each output transfer; wraps modulo 2^32.
  - instr_count +1 on each output transfer.
- clear (rst high): same effect as reset on buffer, out_addr, err_sticky and instr_count. Any in-flight input in that cycle is dropped. clear has priority over push/pop.
- rst has priority over clear. Reset mid-stream discards buffered words.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_IALU, OP_R);
  - format codes FMT_* matching the 3-bit immediate-select encoding used by the core;
  - NOP_WORD = 32'h0000_0013.
- Sub-module rv32i_field_pack: purely combinational fields -> {instr, err}. The top holds the FIFO, address and counters.

Test Plan:
- rst low 2 cycles, then high → out_valid=0, in_ready=1, out_addr=0, instr_count=0, err_sticky=0.
- With out_ready=1, send four bundles back-to-back:
  - R add rd3 rs1 1 rs2 2 f3 0 f7 0;
  - load rd5 rs1 2 f3 010 imm 8;
  - store rs1 2 rs2 5 f3 010 imm 12;
  - jal rd1 imm 8.
  - Expect 0x002081B3 @0, 0x00812283 @4, 0x00512623 @8, 0x008000EF @12, each one cycle after its input; instr_count=4.
- Branch rs1 1 rs2 2 f3 0 imm -4 → 0xFE208EE3, out_err=0.
- Three cases:
  - I-ALU imm 4096;
  - branch imm 6'd3 (odd);
  - fmt 111.
  - Each → 0x00000013 with out_err=1; err_sticky=1 until clear.
- out_ready=0 and push 3 bundles → first two accepted, in_ready=0 after the second. Raise out_ready → words drain in order, addresses consecutive, third accepted, no loss or duplication.
- With 2 words buffered and out_addr=16, pulse clear → next cycle out_valid=0, out_addr=BASE_ADDR, instr_count=0, err_sticky=0. Repeat with rst low mid-stream for the same result.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions.
// Holds the opcode constants, the format-select codes carried on in_fmt, the canonical NOP
// word, and a helper for signed-immediate range checks.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    localparam logic [2:0] FMT_LOAD   = 3'b000;
    localparam logic [2:0] FMT_STORE  = 3'b001;
    localparam logic [2:0] FMT_BRANCH = 3'b010;
    localparam logic [2:0] FMT_JAL    = 3'b011;
    localparam logic [2:0] FMT_IALU   = 3'b100;
    localparam logic [2:0] FMT_R      = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when imm is representable as a signed value of the given bit width, i.e. every
    // bit from width-1 upward equals the sign bit.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned width);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i + 1 >= width) && (imm[i] != imm[31])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_field_pack.sv
// Combinational RV32I field packer.
// Ports:
//   i_fmt, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm : instruction fields
//   o_instr : packed 32-bit machine word (NOP_WORD when the request is rejected)
//   o_err   : request was illegal or its immediate was out of range
module rv32i_field_pack
    import rv32i_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    always_comb begin
        o_instr = NOP_WORD;
        o_err   = 1'b1;
        case (i_fmt)
            FMT_LOAD, FMT_IALU: begin
                if (imm_fits(i_imm, 12)) begin
                    o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd,
                               (i_fmt == FMT_LOAD) ? OP_LOAD : OP_IALU};
                    o_err   = 1'b0;
                end
            end
            FMT_STORE: begin
                if (imm_fits(i_imm, 12)) begin
                    o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
                    o_err   = 1'b0;
                end
            end
            FMT_BRANCH: begin
                // Byte offset must be halfword aligned; bit 0 is not encoded.
                if (imm_fits(i_imm, 13) && !i_imm[0]) begin
                    o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], OP_BRANCH};
                    o_err   = 1'b0;
                end
            end
            FMT_JAL: begin
                if (imm_fits(i_imm, 21) && !i_imm[0]) begin
                    o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                    o_err   = 1'b0;
                end
            end
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
                o_err   = 1'b0;
            end
            default: begin
                o_instr = NOP_WORD;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I instruction encoder.
// Packs field bundles into machine words and emits them, with their instruction-memory byte
// address, through a 2-entry skid FIFO.
// Ports:
//   clk, rst (sync, active low), clear (sync flush)
//   in_valid/in_ready + in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//   out_valid/out_ready + out_instr, out_addr, out_err
//   err_sticky  : some word was substituted since reset/clear
//   instr_count : output transfers since reset/clear
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_sticky,
    output logic [15:0] instr_count
);

    logic [31:0] w_pack_instr;
    logic        w_pack_err;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_next;

    logic [31:0] r_mem_instr [2];
    logic        r_mem_err   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_in_ready;
    logic [31:0] r_addr;
    logic        r_err_sticky;
    logic [15:0] r_instr_count;

    rv32i_field_pack u_field_pack (
        .i_fmt    (in_fmt),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_instr  (w_pack_instr),
        .o_err    (w_pack_err)
    );

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // rst and clear share one flush path; rst simply wins by being the same action.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_mem_instr[0] <= '0;
            r_mem_instr[1] <= '0;
            r_mem_err[0]   <= 1'b0;
            r_mem_err[1]   <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
            r_in_ready     <= 1'b1;
            r_addr         <= BASE_ADDR;
            r_err_sticky   <= 1'b0;
            r_instr_count  <= 16'd0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_pack_instr;
                r_mem_err[r_wr_ptr]   <= w_pack_err;
                r_wr_ptr              <= ~r_wr_ptr;
                if (w_pack_err) begin
                    r_err_sticky <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr      <= ~r_rd_ptr;
                r_addr        <= r_addr + 32'd4;
                r_instr_count <= r_instr_count + 16'd1;
            end
            r_count    <= w_count_next;
            // Registered ready: depends only on the next occupancy, never on out_ready directly.
            r_in_ready <= (32'(w_count_next) < DEPTH);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_instr   = r_mem_instr[r_rd_ptr];
    assign out_err     = r_mem_err[r_rd_ptr];
    assign out_addr    = r_addr;
    assign err_sticky  = r_err_sticky;
    assign instr_count = r_instr_count;

endmodule
